life_engine: RTL and testbench

Parametrised cellular-automaton engine with a configurable board size, outer-totalistic rule masks (B/S), and a toroidal or dead-boundary edge mode. Two ping-pong board banks remove the copy phase: each generation is read from the display bank, written to the other bank, and the banks swap on completion. It sits between the VGA timing generator and the pixel mux. The display reads cells through an asynchronous read port. A write port loads patterns.

---
 rtl/life_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_life_engine.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine.sv
`timescale 1ns/1ps
// life_engine: outer-totalistic cellular automaton on a W x H board.
// Two board banks ping-pong: one generation is read from the display bank
// and written to the other, then the banks swap, so the display never sees
// a partially updated frame. Cells are addressed {y,x}.
module life_engine #(
    parameter int LOG_W      = 6,
    parameter int LOG_H      = 5,
    parameter int UPDATE_DIV = 2400000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   step,
    input  logic                   randomize,
    input  logic                   frame_sync,
    input  logic                   wrap_en,
    input  logic [8:0]             birth_mask,
    input  logic [8:0]             survive_mask,
    input  logic                   wr_en,
    input  logic [LOG_W+LOG_H-1:0] wr_addr,
    input  logic                   wr_data,
    input  logic [LOG_W+LOG_H-1:0] rd_addr,
    output logic                   rd_data,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            gen_count,
    output logic [LOG_W+LOG_H:0]   population
);

    localparam int W  = 1 << LOG_W;
    localparam int H  = 1 << LOG_H;
    localparam int N  = W * H;
    localparam int AW = LOG_W + LOG_H;
    localparam int TW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [TW-1:0] T_MAX     = TW'(UPDATE_DIV - 1);
    localparam logic [AW-1:0] LAST_CELL = AW'(N - 1);
    localparam logic [AW-1:0] PREV_CELL = AW'(N - 2);

    typedef enum logic [1:0] {INIT, IDLE, UPDATE} state_t;

    state_t          state;
    logic            bank_sel;
    logic [N-1:0]    bank0;
    logic [N-1:0]    bank1;
    logic [N-1:0]    disp_bank;
    logic [15:0]     lfsr;
    logic [TW-1:0]   timer;
    logic            pending;
    logic [AW-1:0]   idx;
    logic [3:0]      phase;
    logic [3:0]      nbr_cnt;
    logic [AW:0]     new_pop;
    logic            wrap_q;
    logic [8:0]      birth_q;
    logic [8:0]      survive_q;
    logic            trigger;

    logic [LOG_W-1:0]        cell_x;
    logic [LOG_H-1:0]        cell_y;
    logic signed [1:0]       dx;
    logic signed [1:0]       dy;
    logic signed [LOG_W+1:0] nx;
    logic signed [LOG_H+1:0] ny;
    logic                    nbr_in_range;
    logic [AW-1:0]           nbr_addr;
    logic                    nbr_bit;
    logic                    cur_bit;
    logic                    next_bit;

    logic                    we;
    logic                    we_sel;
    logic [AW-1:0]           we_addr;
    logic                    we_data;

    assign disp_bank = bank_sel ? bank1 : bank0;
    assign rd_data   = disp_bank[rd_addr];
    assign busy      = (state != IDLE);
    assign cell_x    = idx[LOG_W-1:0];
    assign cell_y    = idx[AW-1:LOG_W];
    assign cur_bit   = disp_bank[idx];
    assign next_bit  = cur_bit ? survive_q[nbr_cnt] : birth_q[nbr_cnt];
    assign trigger   = (pending || (timer == T_MAX)) && frame_sync;

    // Neighbour selected by the current phase; out-of-range neighbours read as dead unless wrapping
    always_comb begin
        dx = 2'sd0;
        dy = 2'sd0;
        case (phase)
            4'd0: begin dx = -2'sd1; dy =  2'sd1; end
            4'd1: begin dx =  2'sd0; dy =  2'sd1; end
            4'd2: begin dx =  2'sd1; dy =  2'sd1; end
            4'd3: begin dx = -2'sd1; dy =  2'sd0; end
            4'd4: begin dx =  2'sd1; dy =  2'sd0; end
            4'd5: begin dx = -2'sd1; dy = -2'sd1; end
            4'd6: begin dx =  2'sd0; dy = -2'sd1; end
            4'd7: begin dx =  2'sd1; dy = -2'sd1; end
            default: ;
        endcase
        nx = $signed({2'b00, cell_x}) + $signed({{LOG_W{dx[1]}}, dx});
        ny = $signed({2'b00, cell_y}) + $signed({{LOG_H{dy[1]}}, dy});
        // x+dx lies in [-1, W]: both -1 and W set one of the two guard bits
        nbr_in_range = (nx[LOG_W+1:LOG_W] == 2'b00) && (ny[LOG_H+1:LOG_H] == 2'b00);
        nbr_addr     = {ny[LOG_H-1:0], nx[LOG_W-1:0]};
        nbr_bit      = disp_bank[nbr_addr] & (wrap_q | nbr_in_range);
    end

    // Single bank write port: INIT fill, IDLE pattern load, or UPDATE result into the back bank
    always_comb begin
        we      = 1'b0;
        we_sel  = bank_sel;
        we_addr = idx;
        we_data = 1'b0;
        case (state)
            INIT: begin
                we      = 1'b1;
                we_data = lfsr[0];
            end
            IDLE: begin
                if (wr_en) begin
                    we      = 1'b1;
                    we_addr = wr_addr;
                    we_data = wr_data;
                end
            end
            UPDATE: begin
                if (phase == 4'd8) begin
                    we      = 1'b1;
                    we_sel  = ~bank_sel;
                    we_data = next_bit;
                end
            end
            default: ;
        endcase
    end

    // Board storage; contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            if (we_sel) bank1[we_addr] <= we_data;
            else        bank0[we_addr] <= we_data;
        end
    end

    // Control FSM, LFSR, pacing timer and statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            bank_sel   <= 1'b0;
            lfsr       <= 16'hACE1;
            timer      <= '0;
            pending    <= 1'b0;
            idx        <= '0;
            phase      <= '0;
            nbr_cnt    <= '0;
            new_pop    <= '0;
            wrap_q     <= 1'b0;
            birth_q    <= '0;
            survive_q  <= '0;
            done       <= 1'b0;
            gen_count  <= '0;
            population <= '0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            done <= 1'b0;
            if (step) pending <= 1'b1;
            case (state)
                INIT: begin
                    gen_count  <= '0;
                    population <= population + {{AW{1'b0}}, lfsr[0]};
                    if (idx == PREV_CELL) done <= 1'b1;
                    if (idx == LAST_CELL) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                IDLE: begin
                    if (run && (timer != T_MAX)) timer <= timer + TW'(1);
                    if (trigger) begin
                        timer     <= '0;
                        pending   <= step;
                        wrap_q    <= wrap_en;
                        birth_q   <= birth_mask;
                        survive_q <= survive_mask;
                        idx       <= '0;
                        phase     <= '0;
                        nbr_cnt   <= '0;
                        new_pop   <= '0;
                        if (randomize) begin
                            population <= '0;
                            state      <= INIT;
                        end else begin
                            state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    if (phase != 4'd8) begin
                        nbr_cnt <= nbr_cnt + {3'b000, nbr_bit};
                        phase   <= phase + 4'd1;
                        if ((idx == LAST_CELL) && (phase == 4'd7)) done <= 1'b1;
                    end else begin
                        phase   <= '0;
                        nbr_cnt <= '0;
                        new_pop <= new_pop + {{AW{1'b0}}, next_bit};
                        if (idx == LAST_CELL) begin
                            bank_sel   <= ~bank_sel;
                            population <= new_pop + {{AW{1'b0}}, next_bit};
                            gen_count  <= gen_count + 16'd1;
                            idx        <= '0;
                            state      <= IDLE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_life_engine.sv
`timescale 1ns/1ps
// tb_life_engine: scoreboard bench for life_engine on an 8x8 board.
// Stimulus pushes expected results computed by a plain array model of the
// rules; a monitor pops one entry per done pulse and checks the board.
module tb_life_engine;

    localparam int LW  = 3;
    localparam int LH  = 3;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int N   = 64;
    localparam int DIV = 100;
    localparam logic [8:0] B3  = 9'b000001000;
    localparam logic [8:0] S23 = 9'b000001100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        randomize = 1'b0;
    logic        frame_sync = 1'b0;
    logic        wrap_en = 1'b0;
    logic [8:0]  birth_mask = '0;
    logic [8:0]  survive_mask = '0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic        wr_data = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic        rd_data;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [6:0]  population;

    life_engine #(.LOG_W(LW), .LOG_H(LH), .UPDATE_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .randomize(randomize),
        .frame_sync(frame_sync), .wrap_en(wrap_en), .birth_mask(birth_mask),
        .survive_mask(survive_mask), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .gen_count(gen_count), .population(population)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;      // 0 known INIT board, 1 generation, 2 random INIT
        int          busy_len;
        int          gen;
        int          pop;
        logic [63:0] board;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mb;
    int          m_gen;
    logic [63:0] scan_board;
    bit          mon_active = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rule: count the eight neighbours of every cell directly
    function automatic logic [63:0] life_next(input logic [63:0] b, input logic [8:0] bm,
                                              input logic [8:0] sm, input bit wrap);
        logic [63:0] r;
        int c, xx, yy;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                c = 0;
                for (int ddy = -1; ddy <= 1; ddy++) begin
                    for (int ddx = -1; ddx <= 1; ddx++) begin
                        if (ddx == 0 && ddy == 0) continue;
                        xx = x + ddx;
                        yy = y + ddy;
                        if (wrap) begin
                            xx = (xx + W) % W;
                            yy = (yy + H) % H;
                        end else if (xx < 0 || xx >= W || yy < 0 || yy >= H) begin
                            continue;
                        end
                        c += int'(b[yy*W + xx]);
                    end
                end
                r[y*W + x] = b[y*W + x] ? sm[c] : bm[c];
            end
        end
        return r;
    endfunction

    // Board produced by INIT straight after reset: successive LFSR low bits
    function automatic logic [63:0] init_board();
        logic [63:0] r;
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < N; i++) begin
            r[i] = l[0];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int x, input int y, input bit v);
        wr_en   = 1'b1;
        wr_addr = 6'(y*W + x);
        wr_data = v;
        tick();
        wr_en   = 1'b0;
        mb[y*W + x] = v;
    endtask

    task automatic load_board(input logic [63:0] b);
        for (int a = 0; a < N; a++) write_cell(a % W, a / W, b[a]);
    endtask

    task automatic push_update(input logic [8:0] bm, input logic [8:0] sm, input bit wr);
        exp_t e;
        logic [63:0] nb;
        nb = life_next(mb, bm, sm, wr);
        m_gen = (m_gen + 1) % 65536;
        e.kind = 1; e.busy_len = 9*N; e.gen = m_gen; e.pop = $countones(nb); e.board = nb;
        sb.push_back(e);
        mb = nb;
    endtask

    task automatic push_init(input int kind, input logic [63:0] b);
        exp_t e;
        e.kind = kind; e.busy_len = N; e.gen = 0; e.pop = $countones(b); e.board = b;
        sb.push_back(e);
    endtask

    task automatic wait_sb();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && !mon_active && !busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 20 && !busy; k++) tick();
    endtask

    task automatic set_rule(input logic [8:0] bm, input logic [8:0] sm, input bit wr);
        birth_mask = bm; survive_mask = sm; wrap_en = wr;
    endtask

    task automatic do_step(input logic [8:0] bm, input logic [8:0] sm, input bit wr);
        set_rule(bm, sm, wr);
        push_update(bm, sm, wr);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_sb();
    endtask

    // Monitor: one scoreboard entry per done pulse, board scanned through rd_data
    initial begin : monitor
        int blen;
        exp_t e;
        logic [63:0] sc;
        blen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                blen = 0;
            end else begin
                if (busy) blen++;
                if (done) begin
                    @(negedge clk);
                    mon_active = 1'b1;
                    check("done_one_cycle", done, 0);
                    check("busy_after_done", busy, 0);
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got a done pulse, expected none");
                    end else begin
                        e = sb.pop_front();
                        check("busy_len", blen, e.busy_len);
                        check("gen_count", gen_count, e.gen);
                        sc = '0;
                        for (int a = 0; a < N; a++) begin
                            rd_addr = 6'(a);
                            #0.05;
                            sc[a] = rd_data;
                        end
                        check("population_vs_cells", population, $countones(sc));
                        if (e.kind != 2) begin
                            check("population", population, e.pop);
                            check("board", sc, e.board);
                        end
                        scan_board = sc;
                    end
                    blen = 0;
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [63:0] ib;
        int starts;
        ib = init_board();

        // Reset and the LFSR fill that follows release
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", busy, 1);
        check("reset_done", done, 0);
        check("reset_gen", gen_count, 0);
        check("reset_pop", population, 0);
        push_init(0, ib);
        repeat (3) tick();
        rst_n = 1'b1;
        wait_sb();
        mb = ib;
        m_gen = 0;
        frame_sync = 1'b1;

        // Blinker, toroidal, two generations
        load_board('0);
        write_cell(3, 2, 1'b1); write_cell(3, 3, 1'b1); write_cell(3, 4, 1'b1);
        do_step(B3, S23, 1'b1);
        do_step(B3, S23, 1'b1);

        // Blinker on the left edge, dead boundary then toroidal
        load_board('0);
        write_cell(0, 3, 1'b1); write_cell(0, 4, 1'b1); write_cell(0, 5, 1'b1);
        do_step(B3, S23, 1'b0);
        load_board('0);
        write_cell(0, 3, 1'b1); write_cell(0, 4, 1'b1); write_cell(0, 5, 1'b1);
        do_step(B3, S23, 1'b1);

        // Empty rule kills everything
        load_board({$urandom(), $urandom()});
        do_step(9'h000, 9'h000, 1'b1);

        // Random boards and rules
        for (int it = 0; it < 6; it++) begin
            logic [63:0] rb;
            logic [8:0]  bm, sm;
            bit          wr;
            int          a;
            rb = {$urandom(), $urandom()};
            bm = 9'($urandom());
            sm = 9'($urandom());
            wr = 1'($urandom());
            if (it < 3) begin
                bm = B3;
                sm = S23;
            end
            load_board(rb);
            set_rule(bm, sm, wr);
            if (it == 0) begin
                // Pattern writes while busy must not land
                push_update(bm, sm, wr);
                step = 1'b1; tick(); step = 1'b0;
                wait_busy();
                for (int k = 0; k < 700 && busy; k++) begin
                    wr_en = 1'b1; wr_addr = 6'($urandom()); wr_data = 1'($urandom());
                    tick();
                end
                wr_en = 1'b0;
                wait_sb();
            end else if (it == 1) begin
                // Step during busy queues a second generation
                push_update(bm, sm, wr);
                push_update(bm, sm, wr);
                step = 1'b1; tick(); step = 1'b0;
                wait_busy();
                repeat (100) tick();
                step = 1'b1; tick(); step = 1'b0;
                wait_sb();
            end else if (it == 2) begin
                // Write on the trigger cycle lands before the generation reads it
                step = 1'b1; tick(); step = 1'b0;
                a = $urandom_range(0, N-1);
                wr_en = 1'b1; wr_addr = 6'(a); wr_data = ~mb[a];
                mb[a] = ~mb[a];
                push_update(bm, sm, wr);
                tick();
                wr_en = 1'b0;
                wait_sb();
            end else begin
                do_step(bm, sm, wr);
            end
        end

        // Free run is gated by frame_sync
        load_board({$urandom(), $urandom()});
        set_rule(B3, S23, 1'b1);
        frame_sync = 1'b0;
        run = 1'b1;
        starts = 0;
        repeat (150) begin
            tick();
            if (busy) starts++;
        end
        check("no_start_without_frame_sync", starts, 0);
        push_update(B3, S23, 1'b1);
        frame_sync = 1'b1;
        tick();
        check("update_starts_next_cycle", busy, 1);
        run = 1'b0;
        wait_sb();

        // randomize at a timer trigger re-seeds
        frame_sync = 1'b0;
        run = 1'b1;
        repeat (110) tick();
        randomize = 1'b1;
        push_init(2, '0);
        frame_sync = 1'b1;
        tick();
        check("init_on_randomize", busy, 1);
        run = 1'b0;
        randomize = 1'b0;
        wait_sb();
        mb = scan_board;
        m_gen = 0;

        // step together with randomize also re-seeds
        do_step(B3, S23, 1'b0);
        randomize = 1'b1;
        push_init(2, '0);
        step = 1'b1; tick(); step = 1'b0;
        wait_busy();
        randomize = 1'b0;
        wait_sb();
        mb = scan_board;
        m_gen = 0;

        // Reset in the middle of a generation (cell 20)
        set_rule(B3, S23, 1'b1);
        step = 1'b1; tick(); step = 1'b0;
        wait_busy();
        repeat (180) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 1);
        check("midreset_done", done, 0);
        check("midreset_gen", gen_count, 0);
        check("midreset_pop", population, 0);
        push_init(0, ib);
        repeat (3) tick();
        rst_n = 1'b1;
        wr_en = 1'b1; wr_addr = 6'd0; wr_data = ~ib[0];
        for (int k = 0; k < 200 && busy; k++) tick();
        wr_en = 1'b0;
        wait_sb();
        mb = ib;
        m_gen = 0;
        do_step(B3, S23, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
